div_arbiter: RTL

//  Two-requester scheduler in front of one `operacion` restoring-divider core.

---
 rtl/div_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/div_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Operand/result width of the divider core.
    localparam int W = 4;

    // Core latency: four quotient bits, each taking scan_div cycles, plus
    // two cycles of core-internal setup/settle.
    function automatic int lat(input int scan_div);
        return 4 * scan_div + 2;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: picks the requester that was not granted last on a tie.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the grant.
//
// Ports:
//   req        in  2  level requests
//   last_grant in  1  index granted most recently
//   grant_vld  out 1  at least one request present
//   grant_idx  out 1  winning requester index
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_vld,
    output logic       grant_idx
);

    always_comb begin
        grant_vld = |req;
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/div_arbiter.sv
// Schedules two requesters onto one restoring-divider core; traps divide-by-zero locally.
// Latency: ack 1+LOAD_CYC+LAT cycles after the granting edge (1 cycle for divide-by-zero).
// Backpressure: requests are level-held; a requester waits with req high until its ack.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req[1:0]                      per-requester request, held until ack
//   dividendo0/1, divisor0/1      requester operands, stable while req high
//   ack[1:0]                      one-hot, one-cycle result pulse
//   cociente, resto, err_div0     result (held until next ack), div-by-zero flag with ack
//   busy                          not idle
//   core_rst_n, core_dividendo,   core interface: active-low load, registered operands
//   core_divisor
//   core_cociente, core_resto     core results
module div_arbiter #(
    parameter int SCAN_DIV = 4,
    parameter int W        = div_pkg::W,
    parameter int LOAD_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [W-1:0] dividendo0,
    input  logic [W-1:0] divisor0,
    input  logic [W-1:0] dividendo1,
    input  logic [W-1:0] divisor1,
    output logic [1:0]   ack,
    output logic [W-1:0] cociente,
    output logic [W-1:0] resto,
    output logic         err_div0,
    output logic         busy,
    output logic         core_rst_n,
    output logic [W-1:0] core_dividendo,
    output logic [W-1:0] core_divisor,
    input  logic [W-1:0] core_cociente,
    input  logic [W-1:0] core_resto
);

    import div_pkg::*;

    localparam int LAT   = lat(SCAN_DIV);
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_M1 = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    div_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           g_q, g_d;
    logic           last_grant_q, last_grant_d;
    logic           err_q, err_d;
    logic [W-1:0]   cociente_q, cociente_d;
    logic [W-1:0]   resto_q, resto_d;
    logic [W-1:0]   core_dividendo_q, core_dividendo_d;
    logic [W-1:0]   core_divisor_q, core_divisor_d;

    logic           grant_vld;
    logic           grant_idx;
    logic [W-1:0]   sel_dividendo;
    logic [W-1:0]   sel_divisor;

    rr_arbiter2 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant_vld  (grant_vld),
        .grant_idx  (grant_idx)
    );

    assign sel_dividendo = grant_idx ? dividendo1 : dividendo0;
    assign sel_divisor   = grant_idx ? divisor1   : divisor0;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        g_d              = g_q;
        last_grant_d     = last_grant_q;
        err_d            = err_q;
        cociente_d       = cociente_q;
        resto_d          = resto_q;
        core_dividendo_d = core_dividendo_q;
        core_divisor_d   = core_divisor_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    g_d              = grant_idx;
                    last_grant_d     = grant_idx;
                    core_dividendo_d = sel_dividendo;
                    core_divisor_d   = sel_divisor;
                    if (sel_divisor == '0) begin
                        // Answer immediately; the core never leaves load.
                        err_d      = 1'b1;
                        cociente_d = '1;
                        resto_d    = sel_dividendo;
                        state_d    = DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = LOAD_M1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (cnt_q == '0) begin
                    cnt_d   = LAT_M1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    cociente_d = core_cociente;
                    resto_d    = core_resto;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                // Always spend one cycle in IDLE before the next grant.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            g_q              <= 1'b0;
            last_grant_q     <= 1'b1;
            err_q            <= 1'b0;
            cociente_q       <= '0;
            resto_q          <= '0;
            core_dividendo_q <= '0;
            core_divisor_q   <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            g_q              <= g_d;
            last_grant_q     <= last_grant_d;
            err_q            <= err_d;
            cociente_q       <= cociente_d;
            resto_q          <= resto_d;
            core_dividendo_q <= core_dividendo_d;
            core_divisor_q   <= core_divisor_d;
        end
    end

    assign ack            = (state_q == DONE) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
    assign err_div0       = (state_q == DONE) && err_q;
    assign busy           = (state_q != IDLE);
    // The core only runs while in RUN; it is held in load everywhere else.
    assign core_rst_n     = (state_q == RUN);
    assign cociente       = cociente_q;
    assign resto          = resto_q;
    assign core_dividendo = core_dividendo_q;
    assign core_divisor   = core_divisor_q;

endmodule
